shift_engine: RTL

Parametrised, multi-cycle shift unit that generalises the lab's fixed 4-bit one-position shifter. It supports a run-time shift amount and four shift modes, and moves the operand one bit position per clock. Operands are accepted and results returned over valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage in the lab datapath.

---
 rtl/shift_engine.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/shift_engine.sv
// shift_engine: multi-cycle shifter, one bit position per clock.
// Commands enter over in_valid/in_ready and results leave over
// out_valid/out_ready. Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge
// where valid && ready are both 1; the producer holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module shift_engine #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] ONE_C   = SHAMT_W'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [1:0]           mode_q, mode_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 carry_q, carry_d;

  logic [SHAMT_W-1:0]   eff_n;
  logic [WIDTH-1:0]     step_data;
  logic                 step_carry;

  // Effective step count: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
  always_comb begin
    eff_n = '0;
    if (in_mode == M_ROR) begin
      eff_n = in_shamt % WIDTH_C;
    end else if (in_shamt > WIDTH_C) begin
      eff_n = WIDTH_C;
    end else begin
      eff_n = in_shamt;
    end
  end

  // One single-bit step of the latched mode applied to the working register.
  always_comb begin
    step_data  = data_q;
    step_carry = carry_q;
    case (mode_q)
      M_LSL: begin
        step_data  = {data_q[WIDTH-2:0], 1'b0};
        step_carry = data_q[WIDTH-1];
      end
      M_LSR: begin
        step_data  = {1'b0, data_q[WIDTH-1:1]};
        step_carry = data_q[0];
      end
      M_ASR: begin
        step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        step_carry = data_q[0];
      end
      default: begin
        step_data  = {data_q[0], data_q[WIDTH-1:1]};
        step_carry = data_q[0];
      end
    endcase
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = eff_n;
          carry_d = 1'b0;
          state_d = (eff_n == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        cnt_d   = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= M_LSL;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Outputs come straight from registers; out_zero is a flag on out_data.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);
  assign state_dbg = state_q;

endmodule
